memwb_stage: RTL

MEM/WB pipeline register and write-back select for the dual-lane MIPS pipeline. It captures the EX/MEM results and the data-memory read data, and selects the primary write-back value. It resolves same-register collisions between the two lanes and drives both write ports of the register file directly. It also keeps a retired-instruction counter for debug and CPI measurement.

---
 rtl/memwb_stage_if.sv | 47 ++++
 rtl/memwb_stage.sv | 71 +++++++
 2 files changed

// File: rtl/memwb_stage_if.sv
// MEM/WB bus bundle: EX/MEM results in, register-file write ports and debug counter out.
// Pure wiring; no storage or latency of its own.
// No backpressure on the bus; the pipeline holds the stage with Stall.
interface memwb_stage_if #(
  parameter int RETIRE_W = 32
);
  logic                EXMEM_Valid;
  logic                EXMEM_RegWrite;
  logic                EXMEM_MemToReg;
  logic                EXMEM_Link;
  logic [31:0]         EXMEM_ALUResult;
  logic [31:0]         EXMEM_PCPlus8;
  logic [31:0]         MemReadData;
  logic [4:0]          EXMEM_WriteRegister;
  logic                EXMEM_Double;
  logic                EXMEM_addi;
  logic [31:0]         EXMEM_ALUResultB;
  logic [4:0]          EXMEM_WriteRegister2;

  logic                RegWrite;
  logic [4:0]          WriteRegister;
  logic [31:0]         WriteData;
  logic                MEMWB_Double;
  logic                MEMWB_addi;
  logic [4:0]          WriteRegister2;
  logic [31:0]         WriteData2;
  logic                MEMWB_Valid;
  logic [RETIRE_W-1:0] RetireCount;

  // Upstream side: drives the EX/MEM results, observes the write-back ports.
  modport master (
    output EXMEM_Valid, EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_Link,
           EXMEM_ALUResult, EXMEM_PCPlus8, MemReadData, EXMEM_WriteRegister,
           EXMEM_Double, EXMEM_addi, EXMEM_ALUResultB, EXMEM_WriteRegister2,
    input  RegWrite, WriteRegister, WriteData, MEMWB_Double, MEMWB_addi,
           WriteRegister2, WriteData2, MEMWB_Valid, RetireCount
  );

  // Stage side: the MEM/WB register itself.
  modport slave (
    input  EXMEM_Valid, EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_Link,
           EXMEM_ALUResult, EXMEM_PCPlus8, MemReadData, EXMEM_WriteRegister,
           EXMEM_Double, EXMEM_addi, EXMEM_ALUResultB, EXMEM_WriteRegister2,
    output RegWrite, WriteRegister, WriteData, MEMWB_Double, MEMWB_addi,
           WriteRegister2, WriteData2, MEMWB_Valid, RetireCount
  );
endinterface

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with write-back select, dual-lane collision resolve and retire counter.
// One cycle: values captured at edge N drive the register-file write ports after edge N.
// Stall holds every output (counter included); Flush loads a bubble and wins over Stall.
module memwb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Stall,
  input  logic         Flush,
  memwb_stage_if.slave bus
);

  logic                en_a;
  logic                en_b;
  logic                same_dst;
  logic [31:0]         wb_sel;
  logic [RETIRE_W-1:0] retire_inc;

  // Lane enables, collision detect (lane B is program-later and wins), primary data select.
  always_comb begin
    en_a       = bus.EXMEM_Valid & bus.EXMEM_RegWrite & (bus.EXMEM_WriteRegister != 5'd0);
    en_b       = bus.EXMEM_Valid & (bus.EXMEM_Double | bus.EXMEM_addi) &
                 (bus.EXMEM_WriteRegister2 != 5'd0);
    same_dst   = (bus.EXMEM_WriteRegister == bus.EXMEM_WriteRegister2);
    wb_sel     = bus.EXMEM_ALUResult;
    if (bus.EXMEM_Link)
      wb_sel = bus.EXMEM_PCPlus8;
    else if (bus.EXMEM_MemToReg)
      wb_sel = bus.MemReadData;
    // Suppressed and $0 writes still retire; a paired op retires two instructions.
    retire_inc = '0;
    if (bus.EXMEM_Valid)
      retire_inc = (bus.EXMEM_Double | bus.EXMEM_addi) ? RETIRE_W'(2) : RETIRE_W'(1);
  end

  // Stage register: Flush loads a bubble, Stall holds, otherwise capture from EX/MEM.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.RegWrite       <= 1'b0;
      bus.WriteRegister  <= '0;
      bus.WriteData      <= '0;
      bus.MEMWB_Double   <= 1'b0;
      bus.MEMWB_addi     <= 1'b0;
      bus.WriteRegister2 <= '0;
      bus.WriteData2     <= '0;
      bus.MEMWB_Valid    <= 1'b0;
      bus.RetireCount    <= '0;
    end else if (Flush) begin
      bus.RegWrite       <= 1'b0;
      bus.WriteRegister  <= '0;
      bus.WriteData      <= '0;
      bus.MEMWB_Double   <= 1'b0;
      bus.MEMWB_addi     <= 1'b0;
      bus.WriteRegister2 <= '0;
      bus.WriteData2     <= '0;
      bus.MEMWB_Valid    <= 1'b0;
    end else if (!Stall) begin
      bus.RegWrite       <= en_a & ~(en_b & same_dst);
      bus.WriteRegister  <= bus.EXMEM_WriteRegister;
      bus.WriteData      <= wb_sel;
      bus.MEMWB_Double   <= en_b & bus.EXMEM_Double;
      bus.MEMWB_addi     <= en_b & bus.EXMEM_addi;
      bus.WriteRegister2 <= bus.EXMEM_WriteRegister2;
      bus.WriteData2     <= bus.EXMEM_ALUResultB;
      bus.MEMWB_Valid    <= bus.EXMEM_Valid;
      bus.RetireCount    <= bus.RetireCount + retire_inc;
    end
  end

endmodule
